// File: rtl/mem_copy_engine_pkg.sv
// mem_copy_pkg: shared types and constants for the block-copy DMA engine.
// Holds the FSM state enum, default bus widths and the wait-counter width.
package mem_copy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        FIN
    } state_t;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_LEN_W  = 16;

    // Bits needed to hold the value READ_LATENCY in the wait counter.
    function automatic int lat_w(input int rl);
        return $clog2(rl + 1);
    endfunction

endpackage

// File: rtl/mem_copy_engine_if.sv
// mem_copy_engine_if: single-port memory bus between the copy engine
// (master: address, wr_en, mem_data_in) and memory (slave: mem_data_out).
interface mem_copy_engine_if
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [ADDR_W-1:0] address;
    logic              wr_en;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport master (
        output address,
        output wr_en,
        output mem_data_in,
        input  mem_data_out
    );

    modport slave (
        input  address,
        input  wr_en,
        input  mem_data_in,
        output mem_data_out
    );

endinterface

// File: rtl/mem_copy_wait_ctr.sv
// mem_copy_wait_ctr: loadable down-counter timing out the read latency.
// Ports: clock, reset_n, load (preset to READ_LATENCY), dec, last (count==1).
module mem_copy_wait_ctr
    import mem_copy_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic dec,
    output logic last
);

    localparam int CW = lat_w(READ_LATENCY);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(READ_LATENCY);
        end else if (dec && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // The count starts at READ_LATENCY in the first wait cycle,
    // so a value of one marks the cycle the read data is valid.
    assign last = (cnt == CW'(1));

endmodule

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies len words from src_addr to dst_addr one word at
// a time. Ports: start/abort control, busy/done/aborted/words_done status,
// mem bus master (address, wr_en, mem_data_in, mem_data_out).
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int LEN_W        = DEF_LEN_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LEN_W-1:0]  words_done,
    mem_copy_engine_if.master mem
);

    state_t            state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx;
    logic [LEN_W-1:0]  idx_nx;
    logic [ADDR_W-1:0] rd_nx;
    logic [ADDR_W-1:0] wr_addr;
    logic              abort_q;
    logic              abort_now;
    logic              wait_last;

    assign idx_nx    = idx + LEN_W'(1);
    assign rd_nx     = src_q + ADDR_W'(idx_nx);
    assign wr_addr   = dst_q + ADDR_W'(idx);
    assign abort_now = abort_q | abort;

    mem_copy_wait_ctr #(
        .READ_LATENCY(READ_LATENCY)
    ) u_wait (
        .clock  (clock),
        .reset_n(reset_n),
        .load   (state == RD),
        .dec    (state == WAIT),
        .last   (wait_last)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            src_q           <= '0;
            dst_q           <= '0;
            len_q           <= '0;
            idx             <= '0;
            abort_q         <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            aborted         <= 1'b0;
            words_done      <= '0;
            mem.address     <= '0;
            mem.wr_en       <= 1'b0;
            mem.mem_data_in <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    mem.address     <= '0;
                    mem.wr_en       <= 1'b0;
                    mem.mem_data_in <= '0;
                    done            <= 1'b0;
                    if (start) begin
                        src_q      <= src_addr;
                        dst_q      <= dst_addr;
                        len_q      <= len;
                        idx        <= '0;
                        words_done <= '0;
                        aborted    <= 1'b0;
                        abort_q    <= 1'b0;
                        if (len != '0) begin
                            state       <= RD;
                            busy        <= 1'b1;
                            mem.address <= src_addr;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    abort_q <= abort_now;
                    state   <= WAIT;
                end
                WAIT: begin
                    abort_q <= abort_now;
                    if (wait_last) begin
                        state           <= WR;
                        mem.address     <= wr_addr;
                        mem.wr_en       <= 1'b1;
                        mem.mem_data_in <= mem.mem_data_out;
                    end
                end
                WR: begin
                    idx             <= idx_nx;
                    words_done      <= words_done + LEN_W'(1);
                    mem.wr_en       <= 1'b0;
                    mem.mem_data_in <= '0;
                    if (idx_nx == len_q || abort_now) begin
                        state       <= FIN;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        aborted     <= abort_now;
                        mem.address <= '0;
                    end else begin
                        state       <= RD;
                        mem.address <= rd_nx;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed and randomized checks of the copy engine
// against behavioural memories, with READ_LATENCY 1 and 3 instances.
module tb_mem_copy_engine;

    typedef struct {
        int a;
        int d;
        int c;
    } acc_t;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start1  = 1'b0;
    logic        start3  = 1'b0;
    logic        abort   = 1'b0;
    logic [15:0] src     = '0;
    logic [15:0] dst     = '0;
    logic [15:0] len     = '0;

    logic        busy1, done1, aborted1;
    logic        busy3, done3, aborted3;
    logic [15:0] wd1, wd3;

    logic        pk_en  = 1'b0;
    logic        pk_sel = 1'b0;
    logic [15:0] pk_a   = '0;
    logic [15:0] pk_d   = '0;

    logic [15:0] mem1 [0:65535];
    logic [15:0] mem3 [0:65535];
    logic [15:0] rd1;
    logic [15:0] p3 [3];

    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   ndone1 = 0;
    acc_t wlog1[$];
    acc_t rlog1[$];
    acc_t wlog3[$];
    acc_t rlog3[$];
    logic prd1 = 1'b0;
    logic prd3 = 1'b0;
    logic [15:0] pa1 = '0;
    logic [15:0] pa3 = '0;

    mem_copy_engine_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();
    mem_copy_engine_if #(.ADDR_W(16), .DATA_W(16)) bus3 ();

    mem_copy_engine #(
        .ADDR_W(16), .DATA_W(16), .LEN_W(16), .READ_LATENCY(1)
    ) dut1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start1),
        .src_addr  (src),
        .dst_addr  (dst),
        .len       (len),
        .abort     (abort),
        .busy      (busy1),
        .done      (done1),
        .aborted   (aborted1),
        .words_done(wd1),
        .mem       (bus1)
    );

    mem_copy_engine #(
        .ADDR_W(16), .DATA_W(16), .LEN_W(16), .READ_LATENCY(3)
    ) dut3 (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start3),
        .src_addr  (src),
        .dst_addr  (dst),
        .len       (len),
        .abort     (abort),
        .busy      (busy3),
        .done      (done3),
        .aborted   (aborted3),
        .words_done(wd3),
        .mem       (bus3)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Memory models: writes on wr_en, reads delayed by the latency.
    always @(posedge clock) begin
        if (bus1.wr_en) mem1[bus1.address] <= bus1.mem_data_in;
        else if (pk_en && !pk_sel) mem1[pk_a] <= pk_d;
        rd1 <= mem1[bus1.address];
    end
    assign bus1.mem_data_out = rd1;

    always @(posedge clock) begin
        if (bus3.wr_en) mem3[bus3.address] <= bus3.mem_data_in;
        else if (pk_en && pk_sel) mem3[pk_a] <= pk_d;
        p3[0] <= mem3[bus3.address];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign bus3.mem_data_out = p3[2];

    // Bus monitors: log writes and the first cycle of each read address.
    always @(negedge clock) begin
        if (done1) ndone1 <= ndone1 + 1;
        if (bus1.wr_en)
            wlog1.push_back('{int'(bus1.address), int'(bus1.mem_data_in), cyc});
        if (busy1 && !bus1.wr_en && !(prd1 && bus1.address == pa1))
            rlog1.push_back('{int'(bus1.address), 0, cyc});
        prd1 <= busy1 && !bus1.wr_en;
        pa1  <= bus1.address;
    end

    always @(negedge clock) begin
        if (bus3.wr_en)
            wlog3.push_back('{int'(bus3.address), int'(bus3.mem_data_in), cyc});
        if (busy3 && !bus3.wr_en && !(prd3 && bus3.address == pa3))
            rlog3.push_back('{int'(bus3.address), 0, cyc});
        prd3 <= busy3 && !bus3.wr_en;
        pa3  <= bus3.address;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input bit sel, input logic [15:0] a,
                        input logic [15:0] d);
        @(negedge clock);
        pk_sel = sel;
        pk_a   = a;
        pk_d   = d;
        pk_en  = 1'b1;
        @(posedge clock);
        #1 pk_en = 1'b0;
    endtask

    // Start a copy; returns cycles from the start cycle to the done cycle,
    // or -1 if done never arrives. ab >= 0 raises abort in cycle start+ab.
    task automatic run(input bit sel, input logic [15:0] s,
                       input logic [15:0] d, input logic [15:0] l,
                       input int ab, output int lat);
        int t0;
        @(posedge clock);
        #1;
        src = s;
        dst = d;
        len = l;
        if (sel) start3 = 1'b1;
        else start1 = 1'b1;
        t0 = cyc;
        @(posedge clock);
        #1;
        start1 = 1'b0;
        start3 = 1'b0;
        lat = -1;
        for (int k = 0; k < 400; k++) begin
            abort = (ab >= 0 && cyc == t0 + ab);
            @(negedge clock);
            if ((sel ? done3 : done1) === 1'b1) begin
                lat = cyc - t0;
                break;
            end
            @(posedge clock);
            #1;
        end
        abort = 1'b0;
    endtask

    initial begin
        int          lat;
        int          w0, r0, nd;
        bit          seen;
        logic [15:0] v [8];
        logic [15:0] a;
        logic [15:0] model [int];

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_wr_en", bus1.wr_en, 0);
        check("rst_address", bus1.address, 0);
        check("rst_data", bus1.mem_data_in, 0);
        check("rst_status", {busy1, done1, aborted1}, 0);
        check("rst_words", wd1, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Basic copy of four words
        v[0] = 16'h1111; v[1] = 16'h2222;
        v[2] = 16'h3333; v[3] = 16'h4444;
        for (int i = 0; i < 4; i++) poke(0, 16'(4 + i), v[i]);
        w0 = wlog1.size();
        run(0, 16'h0004, 16'h0020, 16'd4, -1, lat);
        check("basic_latency", lat, 13);
        check("basic_words", wd1, 4);
        check("basic_wr_cycles", wlog1.size() - w0, 4);
        for (int i = 0; i < 4; i++)
            check("basic_data", mem1[16'h20 + i], v[i]);
        @(negedge clock);
        check("basic_done_pulse", done1, 0);
        check("basic_words_hold", wd1, 4);

        // Zero length
        w0 = wlog1.size();
        r0 = rlog1.size();
        run(0, 16'h0004, 16'h0008, 16'd0, -1, lat);
        check("len0_latency", lat, 1);
        check("len0_words", wd1, 0);
        check("len0_no_write", wlog1.size() - w0, 0);
        check("len0_no_read", rlog1.size() - r0, 0);

        // Address wrap
        for (int i = 0; i < 3; i++) begin
            v[i] = 16'($urandom);
            poke(0, 16'(16'hFFFE + i), v[i]);
        end
        w0 = wlog1.size();
        r0 = rlog1.size();
        run(0, 16'hFFFE, 16'h0010, 16'd3, -1, lat);
        check("wrap_latency", lat, 10);
        check("wrap_reads", rlog1.size() - r0, 3);
        check("wrap_writes", wlog1.size() - w0, 3);
        if (rlog1.size() - r0 == 3 && wlog1.size() - w0 == 3) begin
            check("wrap_rd0", rlog1[r0].a, 32'hFFFE);
            check("wrap_rd1", rlog1[r0 + 1].a, 32'hFFFF);
            check("wrap_rd2", rlog1[r0 + 2].a, 32'h0000);
            for (int i = 0; i < 3; i++) begin
                check("wrap_wr_addr", wlog1[w0 + i].a, 32'h10 + i);
                check("wrap_wr_data", wlog1[w0 + i].d, 32'(v[i]));
            end
        end

        // Abort during the wait of word 2
        for (int i = 0; i < 5; i++) poke(0, 16'(16'h100 + i), 16'($urandom));
        w0 = wlog1.size();
        r0 = rlog1.size();
        run(0, 16'h0100, 16'h0200, 16'd5, 8, lat);
        check("abort_latency", lat, 10);
        check("abort_flag", aborted1, 1);
        check("abort_words", wd1, 3);
        check("abort_writes", wlog1.size() - w0, 3);
        check("abort_reads", rlog1.size() - r0, 3);
        @(negedge clock);
        check("abort_flag_held", aborted1, 1);

        // Random copies against an address-level model
        for (int t = 0; t < 6; t++) begin
            logic [15:0] s, d, l;
            s = 16'($urandom);
            d = 16'($urandom);
            l = 16'($urandom_range(1, 6));
            model.delete();
            for (int i = 0; i < int'(l); i++) begin
                a = s + 16'(i);
                model[int'(a)] = 16'($urandom);
                poke(0, a, model[int'(a)]);
            end
            for (int i = 0; i < int'(l); i++)
                model[int'(d + 16'(i))] = model[int'(s + 16'(i))];
            run(0, s, d, l, -1, lat);
            check("rand_latency", lat, 1 + 3 * int'(l));
            check("rand_words", wd1, l);
            check("rand_aborted", aborted1, 0);
            for (int i = 0; i < int'(l); i++) begin
                a = d + 16'(i);
                check("rand_data", mem1[a], model[int'(a)]);
            end
        end

        // Reset in the middle of a write
        for (int i = 0; i < 4; i++) poke(0, 16'(16'h300 + i), 16'($urandom));
        @(posedge clock);
        #1;
        src = 16'h0300;
        dst = 16'h0400;
        len = 16'd4;
        start1 = 1'b1;
        @(posedge clock);
        #1 start1 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clock);
            seen = bus1.wr_en;
        end
        check("rst_mid_wr_seen", seen, 1);
        nd = ndone1;
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_wr_en", bus1.wr_en, 0);
        check("rst_mid_address", bus1.address, 0);
        check("rst_mid_data", bus1.mem_data_in, 0);
        check("rst_mid_status", {busy1, done1, aborted1}, 0);
        check("rst_mid_words", wd1, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_mid_no_done", ndone1 - nd, 0);
        v[0] = 16'($urandom);
        poke(0, 16'h0500, v[0]);
        run(0, 16'h0500, 16'h0600, 16'd1, -1, lat);
        check("rst_after_latency", lat, 4);
        check("rst_after_data", mem1[16'h0600], v[0]);
        check("rst_after_words", wd1, 1);

        // Read latency of three
        v[0] = 16'($urandom);
        v[1] = 16'($urandom);
        poke(1, 16'h0050, v[0]);
        poke(1, 16'h0051, v[1]);
        w0 = wlog3.size();
        r0 = rlog3.size();
        run(1, 16'h0050, 16'h0060, 16'd2, -1, lat);
        check("rl3_latency", lat, 11);
        check("rl3_words", wd3, 2);
        check("rl3_writes", wlog3.size() - w0, 2);
        check("rl3_reads", rlog3.size() - r0, 2);
        if (wlog3.size() - w0 == 2 && rlog3.size() - r0 == 2) begin
            for (int i = 0; i < 2; i++) begin
                check("rl3_gap", wlog3[w0 + i].c - rlog3[r0 + i].c, 4);
                check("rl3_rd_addr", rlog3[r0 + i].a, 32'h50 + i);
                check("rl3_wr_addr", wlog3[w0 + i].a, 32'h60 + i);
                check("rl3_wr_data", wlog3[w0 + i].d, 32'(v[i]));
            end
        end
        check("rl3_mem0", mem3[16'h0060], v[0]);
        check("rl3_mem1", mem3[16'h0061], v[1]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
